// File: rtl/tlc_pkg.sv
// Shared types for the T-intersection controller and its conflict monitor.
package tlc_pkg;

  typedef enum logic [1:0] {RED, YEL, GRN, BAD} lamp_e;

  typedef enum logic [2:0] {
    F_NONE         = 3'd0,
    F_LAMP         = 3'd1,
    F_CONFLICT     = 3'd2,
    F_SEQ          = 3'd3,
    F_YEL_SHORT    = 3'd4,
    F_ALLRED_SHORT = 3'd5
  } fault_e;

  typedef enum logic {MONITOR, FAULT} mon_state_e;

  // Exactly one lit lamp is a valid aspect; dark or multiple lamps are BAD.
  function automatic lamp_e encode_lamp(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return RED;
      3'b010:  return YEL;
      3'b001:  return GRN;
      default: return BAD;
    endcase
  endfunction

  function automatic logic seq_ok(input lamp_e p, input lamp_e c);
    return (p == c) || (p == GRN && c == YEL) || (p == YEL && c == RED) ||
           (p == RED && c == GRN);
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// One-cycle tick pulse every TICK_DIV clocks; shared with the controller.
module tlc_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(TICK_DIV - 1));
      if (cnt == CW'(TICK_DIV - 1)) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Independent lamp watchdog: latches the first violation and requests forced red.
// Optional flashing-red output is built when TLC_MON_FLASH_EN is defined.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int MIN_YELLOW = 3000,
  parameter int MIN_ALLRED = 1000,
  parameter int FLASH_HALF = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       main_red,
  input  logic       main_yellow,
  input  logic       main_green,
  input  logic       side_red,
  input  logic       side_yellow,
  input  logic       side_green,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       force_red,
  output logic [7:0] fault_count,
  output logic       flash
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int AW = $clog2(MIN_ALLRED + 1);

  logic          tick;
  logic [5:0]    cur, prev;
  logic          sample_valid, primed;
  lamp_e         cur_m, cur_s, prev_m, prev_s;
  logic [YW-1:0] yel_m, yel_s;
  logic [AW-1:0] allred;
  mon_state_e    state;
  fault_e        code_q, next_code;
  logic          chk_lamp, chk_conf, chk_seq, chk_yel, chk_ar;
  logic          do_prime, enter_fault, leave_fault;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cur_m  = encode_lamp(cur[5], cur[4], cur[3]);
  assign cur_s  = encode_lamp(cur[2], cur[1], cur[0]);
  assign prev_m = encode_lamp(prev[5], prev[4], prev[3]);
  assign prev_s = encode_lamp(prev[2], prev[1], prev[0]);

  // cur holds reset zeros until the first edge, so nothing is judged before then.
  assign chk_lamp = sample_valid && (cur_m == BAD || cur_s == BAD);
  assign chk_conf = sample_valid && cur_m != RED && cur_s != RED;
  assign chk_seq  = primed && (!seq_ok(prev_m, cur_m) || !seq_ok(prev_s, cur_s));
  assign chk_yel  = primed &&
                    ((prev_m == YEL && cur_m == RED && yel_m < YW'(MIN_YELLOW)) ||
                     (prev_s == YEL && cur_s == RED && yel_s < YW'(MIN_YELLOW)));
  assign chk_ar   = primed && allred < AW'(MIN_ALLRED) &&
                    ((prev_m == RED && cur_m == GRN) || (prev_s == RED && cur_s == GRN));

  always_comb begin
    next_code = F_NONE;
    if      (chk_lamp) next_code = F_LAMP;
    else if (chk_conf) next_code = F_CONFLICT;
    else if (chk_seq)  next_code = F_SEQ;
    else if (chk_yel)  next_code = F_YEL_SHORT;
    else if (chk_ar)   next_code = F_ALLRED_SHORT;
  end

  assign do_prime    = sample_valid && !primed;
  assign enter_fault = (state == MONITOR) && (next_code != F_NONE);
  assign leave_fault = (state == FAULT) && clear && !chk_lamp && !chk_conf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= '0;
      prev         <= '0;
      sample_valid <= 1'b0;
    end else begin
      cur          <= {main_red, main_yellow, main_green, side_red, side_yellow, side_green};
      prev         <= cur;
      sample_valid <= 1'b1;
    end
  end

  // The first sample after reset/clear has no trusted history, so timers start satisfied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      yel_m  <= '0;
      yel_s  <= '0;
      allred <= '0;
    end else if (do_prime) begin
      yel_m  <= YW'(MIN_YELLOW);
      yel_s  <= YW'(MIN_YELLOW);
      allred <= AW'(MIN_ALLRED);
    end else begin
      if (cur_m != YEL)                         yel_m <= '0;
      else if (tick && yel_m < YW'(MIN_YELLOW)) yel_m <= yel_m + 1'b1;
      if (cur_s != YEL)                         yel_s <= '0;
      else if (tick && yel_s < YW'(MIN_YELLOW)) yel_s <= yel_s + 1'b1;
      if (!(cur_m == RED && cur_s == RED))       allred <= '0;
      else if (tick && allred < AW'(MIN_ALLRED)) allred <= allred + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= MONITOR;
      fault       <= 1'b0;
      code_q      <= F_NONE;
      fault_count <= '0;
      primed      <= 1'b0;
    end else begin
      if (do_prime) primed <= 1'b1;
      case (state)
        MONITOR: if (enter_fault) begin
          state  <= FAULT;
          fault  <= 1'b1;
          code_q <= next_code;
          if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
        end
        FAULT: if (leave_fault) begin
          state  <= MONITOR;
          fault  <= 1'b0;
          code_q <= F_NONE;
          primed <= 1'b0;
        end
        default: state <= MONITOR;
      endcase
    end
  end

  assign fault_code = code_q;
  assign force_red  = fault;

`ifdef TLC_MON_FLASH_EN
  localparam int FW = $clog2(FLASH_HALF + 1);

  logic [FW-1:0] flash_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (enter_fault) begin
      flash     <= 1'b1;
      flash_cnt <= '0;
    end else if (state == MONITOR || leave_fault) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (tick) begin
      if (flash_cnt == FW'(FLASH_HALF - 1)) begin
        flash     <= ~flash;
        flash_cnt <= '0;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
`else
  logic flash_half_unused;
  assign flash_half_unused = (FLASH_HALF != 0);
  assign flash             = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed bench for tlc_conflict_monitor with an expected-value queue and negedge monitor.
module tb_tlc_conflict_monitor;

  localparam int TICK_DIV   = 4;
  localparam int MIN_YELLOW = 3;
  localparam int MIN_ALLRED = 2;
  localparam int FLASH_HALF = 2;
  localparam int W          = 14;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] RY = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       clear;
  logic       fault;
  logic [2:0] fault_code;
  logic       force_red;
  logic [7:0] fault_count;
  logic       flash;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec  = 0;
  int           n_fail = 0;
  logic         chk    = 1'b0;

  tlc_conflict_monitor #(
    .TICK_DIV  (TICK_DIV),
    .MIN_YELLOW(MIN_YELLOW),
    .MIN_ALLRED(MIN_ALLRED),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .main_red   (main_red),
    .main_yellow(main_yellow),
    .main_green (main_green),
    .side_red   (side_red),
    .side_yellow(side_yellow),
    .side_green (side_green),
    .clear      (clear),
    .fault      (fault),
    .fault_code (fault_code),
    .force_red  (force_red),
    .fault_count(fault_count),
    .flash      (flash)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expected vector: {fault, code, force_red, count, flash}
  function automatic logic [W-1:0] mk(input logic f, input logic [2:0] c, input logic [7:0] n);
    logic fl;
`ifdef TLC_MON_FLASH_EN
    fl = f;
`else
    fl = 1'b0;
`endif
    return {f, c, f, n, fl};
  endfunction

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lamps(input logic [2:0] m, input logic [2:0] s);
    {main_red, main_yellow, main_green} = m;
    {side_red, side_yellow, side_green} = s;
  endtask

  task automatic expect_out(input string nm, input logic f, input logic [2:0] c,
                            input logic [7:0] n);
    exp_q.push_back(mk(f, c, n));
    name_q.push_back(nm);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (chk) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      string        nm;
      act = {fault, fault_code, force_red, fault_count, flash};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expected: got %h with empty expected queue", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got fault=%b code=%0d force_red=%b count=%0d flash=%b, expected fault=%b code=%0d force_red=%b count=%0d flash=%b",
                   nm, act[13], act[12:10], act[9], act[8:1], act[0],
                   e[13], e[12:10], e[9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    lamps(G, R);
    step(2);
    expect_out("reset", 1'b0, 3'd0, 8'd0);
    reset = 1'b0;

    // Legal full cycle on both approaches
    step(4);
    lamps(Y, R); step(16);
    lamps(R, R); step(12);
    lamps(R, G); step(4);
    expect_out("legal_mid", 1'b0, 3'd0, 8'd0);
    lamps(R, Y); step(16);
    lamps(R, R); step(12);
    lamps(G, R); step(4);
    expect_out("legal_end", 1'b0, 3'd0, 8'd0);

    // Green/green for one clock
    lamps(G, G); step(1);
    lamps(G, R); step(1);
    expect_out("conflict", 1'b1, 3'd2, 8'd1);
    clear = 1'b1; step(1); clear = 1'b0;
    expect_out("clear_conflict", 1'b0, 3'd0, 8'd1);

    // Green straight to red
    step(3);
    lamps(R, R); step(2);
    expect_out("seq", 1'b1, 3'd3, 8'd2);
    clear = 1'b1; step(1); clear = 1'b0;
    expect_out("clear_seq", 1'b0, 3'd0, 8'd2);

    // Yellow held only two ticks
    step(3);
    lamps(G, R); step(4);
    lamps(Y, R); step(8);
    lamps(R, R); step(2);
    expect_out("yel_short", 1'b1, 3'd4, 8'd3);

    // Asynchronous reset while faulted
    reset = 1'b1;
    lamps(G, R);
    expect_out("reset_mid_fault", 1'b0, 3'd0, 8'd0);
    reset = 1'b0;

    // Side goes green after one all-red tick
    step(4);
    lamps(Y, R); step(16);
    lamps(R, R); step(4);
    lamps(R, G); step(2);
    expect_out("allred_short", 1'b1, 3'd5, 8'd1);

    // Two main lamps lit with clear held throughout
    reset = 1'b1; step(1);
    lamps(G, R);
    reset = 1'b0;
    step(4);
    clear = 1'b1;
    lamps(RY, R); step(2);
    expect_out("lamp", 1'b1, 3'd1, 8'd1);
    step(2);
    expect_out("lamp_clear_ignored", 1'b1, 3'd1, 8'd1);
    lamps(R, R); step(2);
    expect_out("lamp_cleared", 1'b0, 3'd0, 8'd1);
    clear = 1'b0;

    step(2);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
- Independent watchdog on the lamp outputs of the T-intersection traffic controller.
- Samples the six main/side lamp drives and checks lamp legality, main/side conflicts, phase sequence, yellow dwell and all-red clearance.
- On the first violation, latches a fault code and raises force_red; top level uses force_red to override the controller into flashing red.
- Sits beside the controller in the top level and consumes the same lamp wires that drive the pads.

Parameters:
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); must be ≥ 2.
- MIN_YELLOW, 3000, minimum yellow dwell in ticks before red is allowed.
- MIN_ALLRED, 1000, minimum both-red ticks before either approach may turn green.
- FLASH_HALF, 500, ticks per half-period of the flash output (optional feature only).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- main_red / main_yellow / main_green, input, 1 each, main-road lamp drives from the controller.
- side_red / side_yellow / side_green, input, 1 each, side-road lamp drives from the controller.
- clear, input, 1, synchronous fault-clear request, level-sampled.
- fault, output, 1, latched fault indication.
- fault_code, output, 3, latched cause: 0 none, 1 LAMP, 2 CONFLICT, 3 SEQ, 4 YEL_SHORT, 5 ALLRED_SHORT.
- force_red, output, 1, equals fault; override request to the top level.
- fault_count, output, 8, number of faults latched since reset; saturates at 255.
- flash, output, 1, flashing-red drive (optional feature only; tied 0 when compiled out).

Behaviour:
- Reset (async, active-high) clears all outputs and counters: fault=0, fault_code=0, force_red=0, fault_count=0, flash=0; primed=0; FSM enters MONITOR.
- Sampling and encoding:
  - Lamp inputs are registered every clk into cur.
  - The previous sample is held in prev.
  - Each approach is encoded RED/YEL/GRN; if zero or more than one lamp is lit, it encodes BAD.
- Tick generator: pulses tick for one cycle every TICK_DIV clks. Its counter is reset by reset only.
- Checks run on cur, or on prev→cur. Priority when several fire in one cycle: lowest code wins.
  - LAMP: either approach BAD.
  - CONFLICT: both approaches non-RED.
  - SEQ: per approach, any transition other than GRN→YEL, YEL→RED or RED→GRN. Unchanged state is legal.
  - YEL_SHORT: YEL→RED with that approach's yellow counter < MIN_YELLOW.
  - ALLRED_SHORT: RED→GRN on either approach with allred counter < MIN_ALLRED.
- Counters:
  - Per-approach yellow counter: increments on tick while cur is YEL, clears when cur is not YEL, saturates at MIN_YELLOW.
  - Allred counter: increments on tick while both are RED, clears otherwise, saturates at MIN_ALLRED.
- Priming: while primed=0 (first sample after reset or clear), SEQ, YEL_SHORT and ALLRED_SHORT are suppressed. In that same cycle, allred and yellow counters load their saturation values; primed then sets.
- FSM states:
  - MONITOR: any check fires → FAULT. fault/fault_code are updated on that edge; fault_count increments (saturating).
  - FAULT: fault_code is frozen and later violations are ignored. Counters keep running.
  - FAULT → MONITOR: clear=1 and the current sample has no LAMP/CONFLICT. On the transition, fault_code←0 and primed←0.
  - clear while LAMP/CONFLICT is present is ignored; the fault stays latched.
- Latency: a bad input held before edge k is captured at edge k; fault is visible after edge k+1.
- Simultaneous events:
  - Violation and clear in the same cycle in MONITOR: fault latches.
  - Reset mid-FAULT: fault is lost and re-priming occurs.

Optional Feature:
- Macro TLC_MON_FLASH_EN.
- Defined: while fault=1, flash toggles on every FLASH_HALF-th tick, starting high on the cycle fault rises; flash=0 in MONITOR.
- Undefined: flash is constant 0, and the flash counter and FLASH_HALF have no effect.

Decomposition:
- Shared package tlc_pkg holds:
  - lamp_e (RED, YEL, GRN, BAD);
  - fault_e (codes 0–5);
  - mon_state_e (MONITOR, FAULT);
  - function encode_lamp(r,y,g) returning lamp_e.
- Sub-module tlc_tick_gen (parameter TICK_DIV; ports clk, reset, tick), reused by the controller.

Test Plan (TICK_DIV=4, MIN_YELLOW=3, MIN_ALLRED=2, FLASH_HALF=2):
- Legal cycle main G→Y(3 ticks)→R, all-red 2 ticks, side G→Y(3)→R → fault stays 0 throughout; fault_count=0.
- main_green=1 and side_green=1 together for 1 clk → fault=1, fault_code=2 two edges later; force_red=1.
- main_green→main_red direct (skipping yellow) after priming → fault_code=3; then assert clear with legal lamps → fault=0, fault_code=0 next cycle.
- main yellow held 2 ticks then red → fault_code=4. Separately, side RED→GRN after 1 all-red tick → fault_code=5.
- main_red=main_yellow=1 while clear=1 held → fault_code=1 persists and clear is ignored. Lamps fixed, then clear → returns to MONITOR; fault_count=1 after one latched fault.
- With TLC_MON_FLASH_EN, inject conflict → flash=1 immediately, toggling every 8 clks. Assert reset mid-fault → all outputs 0 asynchronously.
